// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
// The memory is 16K words of 36 bits behind an 18-bit word address.
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 18;
  localparam int DEF_DATA_WIDTH = 36;

  typedef enum logic [1:0] {
    RECOVER = 2'd0,
    IDLE    = 2'd1,
    ACCESS  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// On a tie the port that was not served last wins; a lone requester always wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  assign grant = (&req) ? (last ? 2'b01 : 2'b10) : req;

endmodule

// File: rtl/mem_arbiter_2p.sv
// Round-robin arbiter sharing one Avalon-style memory slave between two requesters.
// A recovery gap after every grant keeps the memory's trailing acknowledge from being credited to the wrong port.
module mem_arbiter_2p
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,

  input  logic [ADDR_WIDTH-1:0] i_s0_address,
  input  logic                  i_s0_read,
  input  logic                  i_s0_write,
  input  logic [DATA_WIDTH-1:0] i_s0_writedata,
  output logic [DATA_WIDTH-1:0] o_s0_readdata,
  output logic                  o_s0_waitrequest,

  input  logic [ADDR_WIDTH-1:0] i_s1_address,
  input  logic                  i_s1_read,
  input  logic                  i_s1_write,
  input  logic [DATA_WIDTH-1:0] i_s1_writedata,
  output logic [DATA_WIDTH-1:0] o_s1_readdata,
  output logic                  o_s1_waitrequest,

  output logic [ADDR_WIDTH-1:0] o_m_address,
  output logic                  o_m_read,
  output logic                  o_m_write,
  output logic [DATA_WIDTH-1:0] o_m_writedata,
  input  logic [DATA_WIDTH-1:0] i_m_readdata,
  input  logic                  i_m_waitrequest,

  output logic [1:0]            o_grant
);

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  logic [1:0] req;
  logic [1:0] pick;
  logic       done;

  assign req = {i_s1_read | i_s1_write, i_s0_read | i_s0_write};

  rr_pick2 u_pick (
    .req   (req),
    .last  (last_q),
    .grant (pick)
  );

  // Master side follows the registered grant; outside ACCESS the bus is held quiet.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    o_m_address   = '0;
    o_m_read      = 1'b0;
    o_m_write     = 1'b0;
    o_m_writedata = '0;
    if (state_q == ACCESS) begin
      if (grant_q[1]) begin
        o_m_address   = i_s1_address;
        o_m_read      = i_s1_read;
        o_m_write     = i_s1_write;
        o_m_writedata = i_s1_writedata;
      end else begin
        o_m_address   = i_s0_address;
        o_m_read      = i_s0_read;
        o_m_write     = i_s0_write;
        o_m_writedata = i_s0_writedata;
      end
    end
  end

  assign done = (state_q == ACCESS) && !i_m_waitrequest && (o_m_read || o_m_write);

  assign o_s0_waitrequest = !(done && grant_q[0]);
  assign o_s1_waitrequest = !(done && grant_q[1]);
  assign o_s0_readdata    = i_m_readdata;
  assign o_s1_readdata    = i_m_readdata;
  assign o_grant          = grant_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      RECOVER: begin
        // Wait out the memory's trailing low waitrequest before granting again.
        if (i_m_waitrequest) begin
          if (|req) begin
            state_d = ACCESS;
            grant_d = pick;
          end else begin
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        if (|req) begin
          state_d = ACCESS;
          grant_d = pick;
        end
      end
      ACCESS: begin
        if (done) begin
          state_d = RECOVER;
          grant_d = '0;
          last_d  = grant_q[1];
        end else if (!(o_m_read || o_m_write)) begin
          // Requester withdrew: no acknowledge, fairness history untouched.
          state_d = RECOVER;
          grant_d = '0;
        end
      end
      default: begin
        state_d = RECOVER;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= RECOVER;
      grant_q <= '0;
      last_q  <= 1'b1;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Self-checking bench for mem_arbiter_2p with a registered-waitrequest memory model.
// Per-port scoreboards are filled when a request is driven and drained on each acknowledge.
module tb_mem_arbiter_2p;
  import mem_arb_pkg::*;

  localparam int AW = DEF_ADDR_WIDTH;
  localparam int DW = DEF_DATA_WIDTH;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic [AW-1:0] s_addr [2];
  logic          s_rd [2];
  logic          s_wr [2];
  logic [DW-1:0] s_wdata [2];
  logic [DW-1:0] s_rdata [2];
  logic          s_wait [2];
  logic [AW-1:0] m_address;
  logic          m_read, m_write;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_wait;
  logic [1:0]    grant;

  mem_arbiter_2p dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_s0_address     (s_addr[0]),
    .i_s0_read        (s_rd[0]),
    .i_s0_write       (s_wr[0]),
    .i_s0_writedata   (s_wdata[0]),
    .o_s0_readdata    (s_rdata[0]),
    .o_s0_waitrequest (s_wait[0]),
    .i_s1_address     (s_addr[1]),
    .i_s1_read        (s_rd[1]),
    .i_s1_write       (s_wr[1]),
    .i_s1_writedata   (s_wdata[1]),
    .o_s1_readdata    (s_rdata[1]),
    .o_s1_waitrequest (s_wait[1]),
    .o_m_address      (m_address),
    .o_m_read         (m_read),
    .o_m_write        (m_write),
    .o_m_writedata    (m_wdata),
    .i_m_readdata     (m_rdata),
    .i_m_waitrequest  (m_wait),
    .o_grant          (grant)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Memory: waitrequest is the registered inverse of the request, so it lags by one cycle both ways.
  logic [DW-1:0] mem [16384];
  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      m_wait  <= 1'b0;
      m_rdata <= '0;
      mem[14'o100] <= 36'o123456701234;
    end else begin
      m_wait  <= !(m_read || m_write);
      m_rdata <= mem[m_address[13:0]];
      if (m_write && !m_wait && m_address[AW-1:14] == '0)
        mem[m_address[13:0]] <= m_wdata;
    end
  end

  typedef struct { logic we; logic [DW-1:0] data; } exp_t;
  typedef struct { int port; int cyc; } ack_t;
  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  ack_t ack_log[$];
  int   ack_cnt [2];
  int   ack_cyc [2];
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0o, expected %0o (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    ack_t a;
    forever begin
      @(negedge i_clk);
      if (i_reset_n) begin
        for (int p = 0; p < 2; p++) begin
          if (!s_wait[p]) begin
            check("ack_grant", 64'(grant), (p == 0) ? 64'd1 : 64'd2);
            if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
              n_vec++;
              n_err++;
              $display("FAIL unexpected_ack port %0d: got acknowledge, expected none (cycle %0d)", p, cyc);
            end else begin
              e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              if (!e.we) check($sformatf("readdata_p%0d", p), 64'(s_rdata[p]), 64'(e.data));
            end
            a.port = p;
            a.cyc  = cyc;
            ack_log.push_back(a);
            ack_cnt[p]++;
            ack_cyc[p] = cyc;
          end
        end
      end
    end
  endtask

  task automatic watchdog();
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic start_req(input int p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] exp);
    exp_t e;
    e.we   = we;
    e.data = exp;
    if (p == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    s_addr[p]  = a;
    s_wdata[p] = d;
    s_rd[p]    = !we;
    s_wr[p]    = we;
  endtask

  // Hold the request through the acknowledge edge, then release it.
  task automatic finish_req(input int p, input int c0, output int acyc);
    int budget = 40;
    while (ack_cnt[p] == c0 && budget > 0) begin
      @(posedge i_clk);
      budget--;
    end
    if (ack_cnt[p] == c0) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout port %0d: got no acknowledge, expected one within 40 cycles", p);
    end
    acyc = ack_cyc[p];
    #1;
    s_rd[p] = 1'b0;
    s_wr[p] = 1'b0;
  endtask

  task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] exp,
                       output int c_drv, output int c_ack);
    int c0;
    c0    = ack_cnt[p];
    c_drv = cyc;
    start_req(p, we, a, d, exp);
    finish_req(p, c0, c_ack);
  endtask

  task automatic saturate(input int p);
    int cd, ca;
    for (int k = 0; k < 8; k++) begin
      if (p == 0) issue(0, 1'b0, 18'o000100, '0, 36'o123456701234, cd, ca);
      else        issue(1, 1'b0, 18'o000200, '0, 36'o777777777777, cd, ca);
    end
  endtask

  initial begin
    int c0, c1, cd0, ca0, cd1, ca1, cp2, budget;

    tbl[0] = '{port: 0, we: 1'b1, addr: 18'o000010, wdata: 36'o000000000001, exp: '0};
    tbl[1] = '{port: 1, we: 1'b0, addr: 18'o000010, wdata: '0, exp: 36'o000000000001};
    tbl[2] = '{port: 1, we: 1'b1, addr: 18'o037777, wdata: 36'o525252525252, exp: '0};
    tbl[3] = '{port: 0, we: 1'b0, addr: 18'o037777, wdata: '0, exp: 36'o525252525252};
    tbl[4] = '{port: 0, we: 1'b1, addr: 18'o000000, wdata: 36'o252525252525, exp: '0};
    tbl[5] = '{port: 1, we: 1'b0, addr: 18'o000000, wdata: '0, exp: 36'o252525252525};
    tbl[6] = '{port: 0, we: 1'b0, addr: 18'o000100, wdata: '0, exp: 36'o123456701234};
    tbl[7] = '{port: 1, we: 1'b0, addr: 18'o037777, wdata: '0, exp: 36'o525252525252};

    for (int p = 0; p < 2; p++) begin
      s_addr[p] = '0; s_rd[p] = 1'b0; s_wr[p] = 1'b0; s_wdata[p] = '0;
      ack_cnt[p] = 0; ack_cyc[p] = 0;
    end
    fork
      monitor();
      watchdog();
    join_none

    // Reset with a port-0 read already pending.
    c0 = ack_cnt[0];
    start_req(0, 1'b0, 18'o000100, '0, 36'o123456701234);
    idle(3);
    check("rst_s0_wait", 64'(s_wait[0]), 64'd1);
    check("rst_s1_wait", 64'(s_wait[1]), 64'd1);
    check("rst_m_read", 64'(m_read), 64'd0);
    check("rst_m_write", 64'(m_write), 64'd0);
    check("rst_m_address", 64'(m_address), 64'd0);
    check("rst_m_wdata", 64'(m_wdata), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    check("rel_mem_wait_low", 64'(m_wait), 64'd0);
    check("rel_no_read_while_wait_low", 64'(m_read), 64'd0);
    idle(1);
    check("rel_mem_wait_high", 64'(m_wait), 64'd1);
    check("rel_still_recover", 64'(m_read), 64'd0);
    idle(1);
    check("first_m_read", 64'(m_read), 64'd1);
    check("first_grant", 64'(grant), 64'd1);
    check("first_m_address", 64'(m_address), 64'o000100);
    cp2 = cyc;
    finish_req(0, c0, ca0);
    check("first_ack_cycle", 64'(ca0), 64'(cp2 + 1));
    idle(3);

    // Table: isolated accesses from IDLE acknowledge in cycle 2.
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp, cd0, ca0);
      check($sformatf("vec%0d_latency", i), 64'(ca0), 64'(cd0 + 2));
      idle(3);
    end

    // Simultaneous write/read of one word: s0 in cycle 2, s1 in cycle 6 sees the new data.
    fork
      issue(0, 1'b1, 18'o000200, 36'o777777777777, '0, cd0, ca0);
      issue(1, 1'b0, 18'o000200, '0, 36'o777777777777, cd1, ca1);
    join
    check("tie_s0_ack_cycle", 64'(ca0), 64'(cd0 + 2));
    check("tie_s1_ack_cycle", 64'(ca1), 64'(cd0 + 6));
    idle(3);

    // Both ports saturated: strict alternation, one access every 4 cycles.
    ack_log.delete();
    fork
      saturate(0);
      saturate(1);
    join
    check("sat_count", 64'(ack_log.size()), 64'd16);
    for (int i = 0; i < ack_log.size(); i++) begin
      check($sformatf("sat_port%0d", i), 64'(ack_log[i].port), 64'(i % 2));
      if (i > 0) check($sformatf("sat_gap%0d", i), 64'(ack_log[i].cyc - ack_log[i-1].cyc), 64'd4);
    end
    idle(3);

    // Abort: s1 withdraws in ACCESS while s0 waits; s0 is served next, s1 never acknowledged.
    c1 = ack_cnt[1];
    s_addr[1] = 18'o000100;
    s_rd[1]   = 1'b1;
    idle(1);
    check("abortA_grant_s1", 64'(grant), 64'd2);
    check("abortA_m_read", 64'(m_read), 64'd1);
    s_rd[1] = 1'b0;
    c0 = ack_cnt[0];
    start_req(0, 1'b0, 18'o000200, '0, 36'o777777777777);
    #1;
    check("abortA_m_read_drop", 64'(m_read), 64'd0);
    idle(1);
    check("abortA_recover_grant", 64'(grant), 64'd0);
    check("abortA_recover_read", 64'(m_read), 64'd0);
    idle(1);
    check("abortA_grant_s0", 64'(grant), 64'd1);
    finish_req(0, c0, ca0);
    check("abortA_no_s1_ack", 64'(ack_cnt[1]), 64'(c1));
    idle(3);

    // Abort must not touch `last` (0 here): a tie right after goes to s1.
    s_addr[1] = 18'o000100;
    s_rd[1]   = 1'b1;
    idle(1);
    check("abortB_grant_s1", 64'(grant), 64'd2);
    s_rd[1] = 1'b0;
    idle(1);
    check("abortB_recover_grant", 64'(grant), 64'd0);
    c0 = ack_cnt[0];
    c1 = ack_cnt[1];
    start_req(0, 1'b0, 18'o000200, '0, 36'o777777777777);
    start_req(1, 1'b0, 18'o000100, '0, 36'o123456701234);
    idle(1);
    check("abortB_last_kept", 64'(grant), 64'd2);
    fork
      finish_req(0, c0, ca0);
      finish_req(1, c1, ca1);
    join
    check("abortB_order", 64'(ca1 < ca0), 64'd1);
    idle(3);

    // Out-of-range write is acknowledged but must not alias onto word 0.
    issue(0, 1'b1, 18'o040000, 36'o111111111111, '0, cd0, ca0);
    check("oor_latency", 64'(ca0), 64'(cd0 + 2));
    idle(3);
    issue(1, 1'b0, 18'o000000, '0, 36'o252525252525, cd1, ca1);
    idle(3);

    check("sb_drain_s0", 64'(exp_q0.size()), 64'd0);
    check("sb_drain_s1", 64'(exp_q1.size()), 64'd0);

    // Reset asserted during the acknowledge cycle.
    start_req(0, 1'b0, 18'o000100, '0, 36'o123456701234);
    budget = 20;
    while (s_wait[0] && budget > 0) begin
      @(negedge i_clk);
      #1;
      budget--;
    end
    check("rstack_reached", 64'(s_wait[0]), 64'd0);
    check("rstack_m_read_before", 64'(m_read), 64'd1);
    i_reset_n = 1'b0;
    #1;
    check("rstack_m_read", 64'(m_read), 64'd0);
    check("rstack_s0_wait", 64'(s_wait[0]), 64'd1);
    check("rstack_s1_wait", 64'(s_wait[1]), 64'd1);
    check("rstack_grant", 64'(grant), 64'd0);
    s_rd[0] = 1'b0;
    idle(1);
    i_reset_n = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_2p.md
# mem_arbiter_2p

Two-port round-robin arbiter that shares one 16K-word, 36-bit on-chip memory between two requesters (e.g. processor bus and console/IO bus). It sits between the requester ports and the memory's single Avalon-style slave port. It serialises accesses and honours the memory's registered waitrequest, which stays low for one cycle after a request drops. It therefore enforces a recovery gap between grants so that a stale acknowledge is never credited to the wrong port.

## Interface
- ADDR_WIDTH, 18, word address width (memory decodes the upper 4 bits itself)
- DATA_WIDTH, 36, data word width
- i_clk  in  1  clock
- i_reset_n  in  1  reset; asynchronous assert, active-low
- i_s0_address / i_s1_address  in  ADDR_WIDTH  requester address
- i_s0_read / i_s1_read  in  1  read request, held until acknowledged
- i_s0_write / i_s1_write  in  1  write request, held until acknowledged
- i_s0_writedata / i_s1_writedata  in  DATA_WIDTH  write data
- o_s0_readdata / o_s1_readdata  out  DATA_WIDTH  read data, valid when that port's waitrequest is low
- o_s0_waitrequest / o_s1_waitrequest  out  1  low for exactly the acknowledge cycle
- o_m_address  out  ADDR_WIDTH  to memory
- o_m_read / o_m_write  out  1  to memory
- o_m_writedata  out  DATA_WIDTH  to memory
- i_m_readdata  in  DATA_WIDTH  from memory
- i_m_waitrequest  in  1  from memory; low means the presented request is accepted
- o_grant  out  2  one-hot current owner, 00 when none

## Operation
- States: RECOVER, IDLE, ACCESS. Reset state is RECOVER because the memory resets its waitrequest low.
- RECOVER: master outputs are all 0. If i_m_waitrequest=1 and a request is pending, go to ACCESS with a new grant. If i_m_waitrequest=1 and nothing is pending, go to IDLE. Otherwise stay.
- IDLE: if any port has read|write, latch the grant and go to ACCESS.
- Grant selection when both ports request: pick the port not in the `last` register. When one port requests, pick it. `last` resets to 1, so port 0 wins the first tie.
- ACCESS: o_m_address, o_m_writedata, o_m_read and o_m_write are driven combinationally from the granted port.
  - When i_m_waitrequest=0 and o_m_read|o_m_write is high, that is the completion cycle. The granted port's waitrequest goes low that cycle, `last` takes the granted index, and the next state is RECOVER.
  - Abort: if the granted port drops both read and write before completion, go to RECOVER with no acknowledge and no change to `last`.
- Read and write asserted together are forwarded unchanged; the memory defines that behaviour.
- o_sN_readdata = i_m_readdata for both ports at all times.
- The ungranted port's waitrequest is always high.
- Outputs after reset: o_s0_waitrequest=1, o_s1_waitrequest=1, o_m_read=0, o_m_write=0, o_m_address=0, o_m_writedata=0, o_grant=00.
- Reset asserted mid-access: immediately enter RECOVER and drop every master output. No acknowledge is issued.

## Timing
- A request first seen at edge e0 is granted at e0. o_m_read/o_m_write are high in cycle 1, the memory acknowledges in cycle 2, and the requester sees waitrequest=0 in cycle 2.
- The requester must drop its request after the acknowledge edge. A request still held in RECOVER counts as a new request.
- RECOVER spans at least 2 cycles, because the memory's waitrequest stays low one cycle after the request drops.
- Back-to-back alternating traffic gives one access per 4 cycles.
- Worst-case wait for a port with both ports saturated is 2 access slots (8 cycles).
- All state and `last` are flops; the master-side mux is combinational from the grant and state registers.

## Structure
- Package mem_arb_pkg holds the state enum (RECOVER, IDLE, ACCESS) and the ADDR_WIDTH/DATA_WIDTH defaults.
- Sub-module rr_pick2 is a combinational two-way round-robin picker: inputs req[1:0] and last, outputs a one-hot grant. It is instantiated once.
- The top level holds the FSM, the grant/last registers and the master mux.

## Test plan
- Reset release with the memory model's waitrequest=0 for 1 cycle: no master request until waitrequest=1, and the first port-0 read of address 0o000100 returns the preloaded 0o123456701234.
- Simultaneous requests, s0 writing 0o777777777777 to 0o000200 and s1 reading 0o000200: s0 is acknowledged in cycle 2, s1 in cycle 6, and s1 reads back 0o777777777777.
- Both ports continuously requesting for 16 accesses: grants strictly alternate 0,1,0,1 and each acknowledge is exactly 4 cycles apart.
- s1 drops read in ACCESS before the acknowledge: no waitrequest-low on s1, `last` unchanged, FSM passes through RECOVER, and s0's pending request is granted next.
- Write to 0o040000 (outside 16K): acknowledged normally, memory contents unchanged.
- Reset asserted in the acknowledge cycle: o_m_read drops asynchronously, both waitrequests go high, o_grant=00.
